// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state codes, PC increment and the buffered fetch entry.
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Control-flow targets must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Single-entry instruction/PC holding register between fetch and decode.
module pc_fetch_unit_fetch_buffer
  import pc_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         consume,
  input  logic         flush,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  // Flush beats load beats consume; a load in the consume cycle keeps the entry valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, control-flow redirect and instruction-memory request sequencing.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        compare_val,
  input  logic [31:0] alu_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic        redirect,
  output logic        misalign_exc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            req_pending_q, req_pending_d;
  logic            take, target_bad, buf_free, ack_fire, buf_load;
  logic [XLEN-1:0] target;
  fetch_entry_t    load_entry, buf_entry;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  // Next state, next PC and the memory-port handshake.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    req_pending_d = req_pending_q;

    take       = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & compare_val));
    target     = ex_is_jalr ? (alu_out & ~XLEN'(1)) : XLEN'(ex_pc + ex_imm);
    target_bad = is_misaligned(target);
    buf_free   = ~if_valid | if_ready;

    // In DROP the stale request stays up on its original address until acked.
    imem_req  = (state_q == FETCH_DROP) |
                ((state_q == FETCH_REQ) & (req_pending_q | buf_free));
    imem_addr = (state_q == FETCH_DROP) ? drop_addr_q : pc_q;
    ack_fire  = imem_req & imem_ack;
    buf_load  = (state_q == FETCH_REQ) & ack_fire & ~take;

    if (ack_fire)      req_pending_d = 1'b0;
    else if (imem_req) req_pending_d = 1'b1;

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (take && imem_req && !imem_ack) begin
          state_d     = FETCH_DROP;
          drop_addr_d = pc_q;
        end
      end
      FETCH_DROP: if (imem_ack) state_d = FETCH_REQ;
      default:    state_d = FETCH_IDLE;
    endcase

    if (take)          pc_d = target_bad ? TRAP_VEC : target;
    else if (buf_load) pc_d = pc_q + PC_INC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      drop_addr_q   <= '0;
      req_pending_q <= 1'b0;
      redirect      <= 1'b0;
      misalign_exc  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      req_pending_q <= req_pending_d;
      redirect      <= take;
      misalign_exc  <= take & target_bad;
    end
  end

  assign load_entry = '{instr: imem_rdata, pc: pc_q};

  pc_fetch_unit_fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .consume    (if_valid & if_ready),
    .flush      (take),
    .load_entry (load_entry),
    .valid      (if_valid),
    .entry      (buf_entry)
  );

  assign if_instr = buf_entry.instr;
  assign if_pc    = buf_entry.pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run against a PC-stream model.
module tb_pc_fetch_unit;

  localparam logic [31:0] KEY  = 32'hC0DE_0000;
  localparam logic [31:0] TRAP = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, compare_val;
  logic [31:0] ex_pc, ex_imm, alu_out;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready, redirect, misalign_exc;
  logic [31:0] if_instr, if_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory image: each word encodes its own address.
  assign imem_rdata = imem_addr ^ KEY;

  pc_fetch_unit #(.RESET_PC(32'h0), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .compare_val(compare_val), .alu_out(alu_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect(redirect), .misalign_exc(misalign_exc)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    compare_val = 0; ex_pc = '0; ex_imm = '0; alu_out = '0;
  endtask

  task automatic test_reset();
    rst = 1; clear_ex(); imem_ack = 0; if_ready = 0;
    step(); step(); #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %0b want 0", if_valid); end
    n_tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_buf: pc %h instr %h want 0", if_pc, if_instr); end
    n_tests++; if (redirect !== 1'b0 || misalign_exc !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: redirect %0b misalign %0b want 0", redirect, misalign_exc); end
    rst = 0; #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %0b want 0", imem_req); end
  endtask

  task automatic test_stream();
    imem_ack = 1; if_ready = 1;
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_addr[%0d]: req %0b addr %h want 1 %h", k, imem_req, imem_addr, 32'(4 * k));
      end
      if (k > 0) begin
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || if_instr !== (32'(4 * (k - 1)) ^ KEY)) begin
          n_fail++; $display("FAIL stream_if[%0d]: valid %0b pc %h instr %h want pc %h", k, if_valid, if_pc, if_instr, 32'(4 * (k - 1)));
        end
      end
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] a;
    imem_ack = 0; #1;
    a = imem_addr;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++; $display("FAIL ack_delay_hold[%0d]: req %0b addr %h want 1 %h", c, imem_req, imem_addr, a);
      end
      step(); #1;
    end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ack_delay_empty: if_valid %0b want 0", if_valid); end
    imem_ack = 1; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_fail++; $display("FAIL ack_delay_last: req %0b addr %h want 1 %h", imem_req, imem_addr, a); end
    step(); #1;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (a ^ KEY)) begin
      n_fail++; $display("FAIL ack_delay_capture: valid %0b pc %h want 1 %h", if_valid, if_pc, a);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = if_pc;
    if_ready = 0; #1;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== held || if_instr !== (held ^ KEY)) begin
        n_fail++; $display("FAIL bp_hold[%0d]: req %0b valid %0b pc %h want 0 1 %h", c, imem_req, if_valid, if_pc, held);
      end
      step(); #1;
    end
    if_ready = 1; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== held + 32'd4) begin n_fail++; $display("FAIL bp_resume: req %0b addr %h want 1 %h", imem_req, imem_addr, held + 32'd4); end
    step(); #1;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== held + 32'd4) begin n_fail++; $display("FAIL bp_next: valid %0b pc %h want 1 %h", if_valid, if_pc, held + 32'd4); end
  endtask

  task automatic test_not_taken();
    logic [31:0] p;
    p = if_pc;
    ex_valid = 1; ex_is_branch = 1; compare_val = 0; ex_pc = 32'h500; ex_imm = 32'h40;
    step(); clear_ex(); #1;
    n_tests++;
    if (redirect !== 1'b0 || if_valid !== 1'b1 || if_pc !== p + 32'd4) begin
      n_fail++; $display("FAIL not_taken: redirect %0b valid %0b pc %h want 0 1 %h", redirect, if_valid, if_pc, p + 32'd4);
    end
  endtask

  task automatic test_branch_drop();
    logic [31:0] old;
    imem_ack = 0;
    ex_valid = 1; ex_is_branch = 1; compare_val = 1; ex_pc = 32'h100; ex_imm = 32'h20;
    #1; old = imem_addr;
    step(); clear_ex(); #1;
    n_tests++; if (redirect !== 1'b1 || misalign_exc !== 1'b0) begin n_fail++; $display("FAIL drop_redirect: redirect %0b misalign %0b want 1 0", redirect, misalign_exc); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_flush: if_valid %0b want 0", if_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== old) begin n_fail++; $display("FAIL drop_hold: req %0b addr %h want 1 %h", imem_req, imem_addr, old); end
    step(); #1;
    n_tests++; if (redirect !== 1'b0 || imem_addr !== old) begin n_fail++; $display("FAIL drop_hold2: redirect %0b addr %h want 0 %h", redirect, imem_addr, old); end
    imem_ack = 1;
    step(); #1;
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: if_valid %0b want 0", if_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h120) begin n_fail++; $display("FAIL drop_refetch: req %0b addr %h want 1 00000120", imem_req, imem_addr); end
    step(); #1;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h120 || if_instr !== (32'h120 ^ KEY)) begin n_fail++; $display("FAIL drop_target: valid %0b pc %h want 1 00000120", if_valid, if_pc); end
  endtask

  task automatic test_jalr_misalign();
    ex_valid = 1; ex_is_jalr = 1; alu_out = 32'h203;
    step(); clear_ex(); #1;
    n_tests++; if (redirect !== 1'b1 || misalign_exc !== 1'b1) begin n_fail++; $display("FAIL jalr_pulses: redirect %0b misalign %0b want 1 1", redirect, misalign_exc); end
    n_tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== TRAP) begin n_fail++; $display("FAIL jalr_trap: valid %0b req %0b addr %h want 0 1 %h", if_valid, imem_req, imem_addr, TRAP); end
    step(); #1;
    n_tests++; if (misalign_exc !== 1'b0 || if_pc !== TRAP) begin n_fail++; $display("FAIL jalr_after: misalign %0b pc %h want 0 %h", misalign_exc, if_pc, TRAP); end
  endtask

  task automatic test_take_with_ack();
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h300; ex_imm = 32'h40;
    step(); clear_ex(); #1;
    n_tests++; if (redirect !== 1'b1 || misalign_exc !== 1'b0) begin n_fail++; $display("FAIL twa_pulses: redirect %0b misalign %0b want 1 0", redirect, misalign_exc); end
    n_tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h340) begin n_fail++; $display("FAIL twa_nodrop: valid %0b req %0b addr %h want 0 1 00000340", if_valid, imem_req, imem_addr); end
    step(); #1;
    n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h340) begin n_fail++; $display("FAIL twa_target: valid %0b pc %h want 1 00000340", if_valid, if_pc); end
  endtask

  // Decode must see a PC stream that steps by 4 and restarts at each resolved target.
  task automatic test_random();
    logic [31:0] exp_pc, p_addr, tgt;
    logic        p_take, p_mis, p_hold, take, mis;
    int          kind, n_cons;
    rst = 1; clear_ex(); imem_ack = 0; if_ready = 0;
    step(); step(); rst = 0;
    exp_pc = 32'h0; p_take = 0; p_mis = 0; p_hold = 0; p_addr = '0; n_cons = 0;
    for (int i = 0; i < 400; i++) begin
      n_tests++;
      if (redirect !== p_take || misalign_exc !== p_mis) begin
        n_fail++; $display("FAIL rnd_pulses[%0d]: redirect %0b misalign %0b want %0b %0b", i, redirect, misalign_exc, p_take, p_mis);
      end
      if (p_take) begin
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush[%0d]: if_valid %0b want 0", i, if_valid); end
      end
      if_ready = ($urandom % 4) != 0;
      clear_ex();
      if (($urandom % 8) == 0) begin
        ex_valid = 1;
        kind = $urandom % 3;
        ex_is_branch = (kind == 0); ex_is_jal = (kind == 1); ex_is_jalr = (kind == 2);
        compare_val = $urandom % 2;
        ex_pc  = 32'($urandom_range(0, 1023)) << 2;
        ex_imm = (32'($urandom_range(0, 63)) << 2) - 32'd128 + ((($urandom % 4) == 0) ? 32'd2 : 32'd0);
        alu_out = $urandom & 32'h0000_0FFF;
      end
      #1;
      if (p_hold) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: req %0b addr %h want 1 %h", i, imem_req, imem_addr, p_addr);
        end
      end
      if (imem_req === 1'b1) begin
        n_tests++; if (imem_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align[%0d]: addr %h want word aligned", i, imem_addr); end
      end
      imem_ack = (imem_req === 1'b1) && (($urandom % 3) != 0);
      #1;
      take = ex_valid && (ex_is_jal || ex_is_jalr || (ex_is_branch && compare_val));
      tgt  = ex_is_jalr ? {alu_out[31:1], 1'b0} : ex_pc + ex_imm;
      mis  = take && (tgt[1:0] != 2'b00);
      if (if_valid === 1'b1 && if_ready && !take) begin
        n_tests++;
        if (if_pc !== exp_pc || if_instr !== (exp_pc ^ KEY)) begin
          n_fail++; $display("FAIL rnd_stream[%0d]: pc %h instr %h want pc %h", i, if_pc, if_instr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (take) exp_pc = mis ? TRAP : tgt;
      p_take = take; p_mis = mis;
      p_hold = (imem_req === 1'b1) && !imem_ack;
      p_addr = imem_addr;
      step();
    end
    n_tests++; if (n_cons < 50) begin n_fail++; $display("FAIL rnd_progress: consumed %0d want >= 50", n_cons); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_ack_delay();
    test_backpressure();
    test_not_taken();
    test_branch_drop();
    test_jalr_misalign();
    test_take_with_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
